// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Bundles the ID/EX issue request, the writeback retire port and the
//   scoreboard's hazard responses into one connection.
//   master : the pipeline side; drives issue_* / flush / wb_*, observes results.
//   slave  : the scoreboard; observes requests, drives stall / fwd_hit /
//            issue_accept / outstanding / busy_vec.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = 3,
  parameter int MAX_OUT  = 4
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  // issue request from ID
  logic                        issue_valid;
  logic                        issue_wen;
  logic [REG_AW-1:0]           issue_rd;
  logic [LAT_W-1:0]            issue_lat;
  logic [NUM_SRC*REG_AW-1:0]   issue_src;
  logic [NUM_SRC-1:0]          issue_src_used;
  logic                        flush;

  // writeback retire
  logic                        wb_valid;
  logic [REG_AW-1:0]           wb_rd;

  // scoreboard responses
  logic                        stall;
  logic [NUM_SRC-1:0]          fwd_hit;
  logic                        issue_accept;
  logic [OUT_W-1:0]            outstanding;
  logic [NUM_REGS-1:0]         busy_vec;

  modport master (
    output issue_valid, issue_wen, issue_rd, issue_lat, issue_src,
           issue_src_used, flush, wb_valid, wb_rd,
    input  stall, fwd_hit, issue_accept, outstanding, busy_vec
  );

  modport slave (
    input  issue_valid, issue_wen, issue_rd, issue_lat, issue_src,
           issue_src_used, flush, wb_valid, wb_rd,
    output stall, fwd_hit, issue_accept, outstanding, busy_vec
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Register-write scoreboard between ID and EX. Each architectural register
//   (except x0) carries a busy bit and a countdown until its in-flight result
//   reaches the bypass network. From that state plus the same-cycle writeback
//   it produces one issue stall and a per-source forward-hit flag.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : hazard_scoreboard_if.slave
//          in  issue_valid, issue_wen, issue_rd, issue_lat, issue_src,
//              issue_src_used, flush, wb_valid, wb_rd
//          out stall, fwd_hit, issue_accept (combinational),
//              outstanding, busy_vec (registered state)
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = 3,
  parameter int MAX_OUT  = 4
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int OUT_W     = $clog2(MAX_OUT + 1);
  // Full index space of a REG_AW-bit register number. Entries that do not map
  // to a tracked register read as idle, so any index is safe to look up.
  localparam int REG_SPACE = 1 << REG_AW;
  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);

  logic [REG_SPACE-1:0] busy_full;
  logic [LAT_W-1:0]     cnt_full [REG_SPACE];

  logic                 rd_tracked;
  logic                 waw_stall;
  logic                 cap_stall;
  logic                 stall_int;
  logic                 accept_int;
  logic                 alloc_en;
  logic                 retire_en;
  logic [NUM_SRC-1:0]   raw_stall;
  logic [NUM_SRC-1:0]   fwd_raw;

  logic [OUT_W-1:0]     outstanding_reg;
  logic [OUT_W-1:0]     outstanding_next;

  // ---------------------------------------------------------------------------
  // Per-register busy/countdown state
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < REG_SPACE; gi++) begin : g_reg
      if (gi == 0 || gi >= NUM_REGS) begin : g_idle
        // x0 and unused index space are never tracked.
        assign busy_full[gi] = 1'b0;
        assign cnt_full[gi]  = '0;
      end else begin : g_track
        localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);

        logic             busy_reg;
        logic [LAT_W-1:0] cnt_reg;
        logic             alloc_hit;
        logic             wb_hit;

        assign alloc_hit = alloc_en && (bus.issue_rd == IDX);
        assign wb_hit    = bus.wb_valid && (bus.wb_rd == IDX);

        // Allocation is checked before retire so that an issue and a
        // writeback to the same register leave the new producer tracked.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
          end else if (alloc_hit) begin
            busy_reg <= 1'b1;
            cnt_reg  <= bus.issue_lat;
          end else if (wb_hit) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
          end else if (busy_reg && (cnt_reg != '0)) begin
            cnt_reg  <= cnt_reg - LAT_W'(1);
          end
        end

        assign busy_full[gi] = busy_reg;
        assign cnt_full[gi]  = cnt_reg;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-source RAW check
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] src;
      logic              pending;

      assign src = bus.issue_src[gi*REG_AW +: REG_AW];

      // A writeback to the same register this cycle is written through to
      // the register file, so the operand is no longer pending.
      assign pending = bus.issue_src_used[gi] && (src != '0) && busy_full[src] &&
                       !(bus.wb_valid && (bus.wb_rd == src));

      // Countdown still running: result not yet on the bypass network.
      assign raw_stall[gi] = pending && (cnt_full[src] != '0);
      assign fwd_raw[gi]   = pending && (cnt_full[src] == '0);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Destination checks and issue decision
  // ---------------------------------------------------------------------------
  assign rd_tracked = bus.issue_wen && (bus.issue_rd != '0);

  // A second writer to a busy register must wait until the older one retires,
  // otherwise the older writeback would clear the newer entry.
  assign waw_stall = rd_tracked && busy_full[bus.issue_rd] &&
                     !(bus.wb_valid && (bus.wb_rd == bus.issue_rd));

  // Any writeback this cycle is taken as freeing a slot.
  assign cap_stall = rd_tracked && (outstanding_reg == MAX_OUT_V) && !bus.wb_valid;

  assign stall_int  = bus.issue_valid && ((|raw_stall) || waw_stall || cap_stall);
  assign accept_int = bus.issue_valid && !stall_int && !bus.flush;
  assign alloc_en   = accept_int && rd_tracked;

  // Only a writeback that hits a tracked entry releases a slot.
  assign retire_en  = bus.wb_valid && (bus.wb_rd != '0) && busy_full[bus.wb_rd];

  // ---------------------------------------------------------------------------
  // Outstanding-write counter
  // ---------------------------------------------------------------------------
  always_comb begin
    outstanding_next = outstanding_reg;
    case ({alloc_en, retire_en})
      2'b10: begin
        // Saturate: a writeback to an idle register can lift the capacity
        // stall while the counter is full, and the count must never wrap.
        if (outstanding_reg != MAX_OUT_V) begin
          outstanding_next = outstanding_reg + OUT_W'(1);
        end
      end
      2'b01: begin
        if (outstanding_reg != '0) begin
          outstanding_next = outstanding_reg - OUT_W'(1);
        end
      end
      default: begin
        outstanding_next = outstanding_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_reg <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.stall        = stall_int;
  assign bus.fwd_hit      = bus.issue_valid ? fwd_raw : '0;
  assign bus.issue_accept = accept_int;
  assign bus.outstanding  = outstanding_reg;
  assign bus.busy_vec     = busy_full[NUM_REGS-1:0];

endmodule
